// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter feeding a downstream FIFO, with one-cycle registered push and occupancy tracking.
// Optional per-requester grant counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_push_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int CAP = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  input  logic           fifo_pop,
  input  logic           fifo_full,
  output logic           fifo_push,
  output logic [W-1:0]   fifo_wdata,
  output logic [1:0]     src_id,
  output logic [1:0]     occ,
  output logic           ovf_err
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [1:0]     stat_sel,
  output logic [7:0]     stat_cnt
`endif
);

  localparam logic [1:0] CAP_V = 2'(CAP);

  logic [1:0]   r_rr_ptr;
  logic [1:0]   r_occ;
  logic         r_push;
  logic [W-1:0] r_wdata;
  logic [1:0]   r_src_id;
  logic         r_ovf_err;

  logic [N-1:0] w_gnt;
  logic [1:0]   w_gnt_idx;
  logic         w_accept;
  logic         w_pop_ok;
  logic [W-1:0] w_slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign w_slice[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // Scan offsets from highest to lowest so the requester closest to rr_ptr wins.
  always_comb begin
    logic [1:0] w_idx;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (req[w_idx]) begin
        w_gnt        = '0;
        w_gnt[w_idx] = 1'b1;
        w_gnt_idx    = w_idx;
      end
    end
    if (!rst || (r_occ == CAP_V)) begin
      w_gnt = '0;
    end
  end

  assign w_accept = |w_gnt;
  assign w_pop_ok = fifo_pop && (r_occ != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= '0;
      r_occ     <= '0;
      r_push    <= 1'b0;
      r_wdata   <= '0;
      r_src_id  <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      r_push <= w_accept;
      if (w_accept) begin
        r_wdata  <= w_slice[w_gnt_idx];
        r_src_id <= w_gnt_idx;
        r_rr_ptr <= w_gnt_idx + 2'd1;
      end
      // occ includes the entry still sitting in the push register.
      case ({w_accept, w_pop_ok})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      r_ovf_err <= (fifo_pop && (r_occ == 2'd0)) || (r_push && fifo_full);
    end
  end

  assign gnt        = w_gnt;
  assign fifo_push  = r_push;
  assign fifo_wdata = r_wdata;
  assign src_id     = r_src_id;
  assign occ        = r_occ;
  assign ovf_err    = r_ovf_err;

`ifdef FIFO_ARB_STATS_EN
  logic [7:0] r_stat_cnt [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stat
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_stat_cnt[gi] <= '0;
        end else if (w_gnt[gi] && (r_stat_cnt[gi] != 8'hFF)) begin
          r_stat_cnt[gi] <= r_stat_cnt[gi] + 8'd1;
        end
      end
    end
  endgenerate

  assign stat_cnt = r_stat_cnt[stat_sel];
`endif

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; fixed at 4 for this release.
REQ-002 Parameter W, default 32: data width.
REQ-003 Parameter CAP, default 3: usable capacity of the downstream FIFO in entries.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N  per-requester push request; held high with data stable until granted.
REQ-007 req_data  input  N*W  packed request data; slice i is bits [i*W+W-1 : i*W].
REQ-008 gnt  output  N  one-hot combinational grant; a transfer occurs on an edge where req[i] and gnt[i] are both high.
REQ-009 fifo_pop  input  1  downstream FIFO pop strobe, one entry per cycle high.
REQ-010 fifo_full  input  1  downstream FIFO full flag, used only for error checking.
REQ-011 fifo_push  output  1  registered push strobe to the downstream FIFO.
REQ-012 fifo_wdata  output  W  registered push data.
REQ-013 src_id  output  2  registered index of the requester whose data is on fifo_wdata.
REQ-014 occ  output  2  current occupancy count, 0..CAP.
REQ-015 ovf_err  output  1  registered error pulse.

Function
REQ-016 Grant eligibility: gnt is all-zero when occ == CAP; pop in the same cycle does not enable a grant.
REQ-017 Round-robin: when eligible, gnt selects the first requester with req high, searching from rr_ptr upward, modulo N.
REQ-018 At most one gnt bit is high in any cycle; gnt is zero when req is zero.
REQ-019 On an accepting edge, rr_ptr becomes granted index + 1 modulo N; otherwise rr_ptr holds.
REQ-020 Latency: one cycle. On the edge after acceptance, fifo_push = 1, fifo_wdata = accepted slice and src_id = granted index.
REQ-021 fifo_push is high for exactly one cycle per accepted transfer; otherwise it is 0.
REQ-022 fifo_wdata and src_id hold their last values when fifo_push = 0.
REQ-023 Occupancy: occ increments on acceptance without pop, decrements on pop without acceptance, and holds when both or neither occur.
REQ-024 occ counts the in-flight registered entry, so back-to-back accepts never exceed CAP.
REQ-025 fifo_pop when occ == 0 is ignored: occ stays 0 and ovf_err pulses for one cycle.
REQ-026 When fifo_push is high while fifo_full is high, ovf_err pulses for one cycle on the next edge.
REQ-027 A requester may drop req at any time before grant, with no state change.
REQ-028 Continuous requests: with all req high and pops keeping occ < CAP, grants rotate 0,1,2,3,0,... with one transfer per cycle.

Reset
REQ-029 While rst is low: gnt = 0, fifo_push = 0, fifo_wdata = 0, src_id = 0, occ = 0, ovf_err = 0 and rr_ptr = 0.
REQ-030 Reset asserted mid-transfer discards the pending registered push, and fifo_push is 0 immediately.
REQ-031 After rst deasserts, the first accept occurs no earlier than the first rising edge.

Configuration
REQ-032 Macro FIFO_ARB_STATS_EN: when defined, the block adds input stat_sel (2 bits) and output stat_cnt (8 bits).
REQ-033 With FIFO_ARB_STATS_EN defined: each requester has one 8-bit counter, incremented once per accepted transfer and saturating at 255.
REQ-034 With FIFO_ARB_STATS_EN defined: stat_cnt combinationally shows the counter selected by stat_sel, and all counters clear to 0 on reset.
REQ-035 Without FIFO_ARB_STATS_EN: stat_sel and stat_cnt ports are absent, no counters exist, and all other behaviour is identical.

Verification
REQ-036 Single request: reset, then req = 0001 with data0 = 0xA5A5A5A5 -> gnt = 0001 immediately; next cycle fifo_push = 1, fifo_wdata = 0xA5A5A5A5, src_id = 0, occ = 1.
REQ-037 Rotation: req = 1111 held, fifo_pop = 1 every cycle after the first push -> gnt sequence 0001, 0010, 0100, 1000, 0001; occ stays at or below 1.
REQ-038 Capacity: req = 0100 held, no pops -> three transfers; occ = 3 and gnt = 0 thereafter; one pop -> occ = 2, then one more grant.
REQ-039 Simultaneous accept and pop at occ = 2 -> occ stays 2; fifo_pop at occ = 0 -> ovf_err = 1 for one cycle and occ = 0.
REQ-040 Reset mid-operation: rst low on the cycle after an accept -> fifo_push = 0 and occ = 0 at once; after release, req = 1000 gets gnt = 1000 because rr_ptr = 0 and lower requesters are idle.
REQ-041 With FIFO_ARB_STATS_EN defined: 300 grants to requester 2 -> stat_sel = 2 reads stat_cnt = 255, and other selects read 0.
